// File: rtl/crc_pkg.sv
// Shared types and elaboration helpers for the parametrised serial CRC engine.
package crc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SHIFT_IN  = 2'd1,
        ST_SHIFT_OUT = 2'd2,
        ST_CHK_DONE  = 2'd3
    } crc_state_e;

    // Beat counter must hold CRC_W itself, not just CRC_W-1.
    function automatic int unsigned crc_cnt_w(input int unsigned w);
        return $clog2(w + 1);
    endfunction

    function automatic bit crc_w_legal(input int unsigned w);
        return (w >= 2) && (w <= 32);
    endfunction

endpackage

// File: rtl/crc_lfsr_step.sv
// One serial LFSR step: shift right, MSB takes feedback, taps XOR feedback.
module crc_lfsr_step #(
    parameter int unsigned CRC_W = 8
) (
    input  logic [CRC_W-1:0] lfsr,
    input  logic             data,
    input  logic [CRC_W-1:0] poly,
    output logic [CRC_W-1:0] next_lfsr_c
);

    logic fb;
    logic unused_poly_msb;

    assign fb              = lfsr[0] ^ data;
    // The MSB always takes the feedback, so its tap bit carries no meaning.
    assign unused_poly_msb = poly[CRC_W-1];

    always_comb begin
        next_lfsr_c          = '0;
        next_lfsr_c[CRC_W-1] = fb;
        for (int i = 0; i < int'(CRC_W) - 1; i++) begin
            next_lfsr_c[i] = lfsr[i+1] ^ (poly[i] & fb);
        end
    end

endmodule

// File: rtl/crc_engine.sv
// Serial CRC generator/checker with backpressured CRC stream, parallel snapshot
// and residue check.
module crc_engine
    import crc_pkg::*;
#(
    parameter int unsigned      CRC_W = 8,
    parameter logic [CRC_W-1:0] POLY  = 8'hC4,
    parameter logic [CRC_W-1:0] SEED  = 8'hD8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             CHECK_MODE,
    input  logic             ACTIVE,
    input  logic             DATA,
    input  logic             OUT_READY,
    output logic             Valid,
    output logic             CRC,
    output logic [CRC_W-1:0] CRC_VAL,
    output logic             BUSY,
    output logic             DONE,
    output logic             CRC_ERR
);

    localparam int unsigned CNT_W = crc_cnt_w(CRC_W);

    if (!crc_w_legal(CRC_W)) begin : g_bad_crc_w
        $error("crc_engine: CRC_W must lie in 2..32");
    end

    crc_state_e       state_q, state_d;
    logic [CRC_W-1:0] lfsr_q, lfsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic [CRC_W-1:0] crc_val_d;
    logic             err_d;
    logic             done_d;
    logic             valid_d;
    logic             crc_d;
    logic             busy_d;
    logic [CRC_W-1:0] step_src_c;
    logic [CRC_W-1:0] step_c;

    // A bit arriving with START is stepped on the fresh seed.
    assign step_src_c = START ? SEED : lfsr_q;

    crc_lfsr_step #(
        .CRC_W (CRC_W)
    ) u_step (
        .lfsr        (step_src_c),
        .data        (DATA),
        .poly        (POLY),
        .next_lfsr_c (step_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        crc_val_d = CRC_VAL;
        err_d     = CRC_ERR;
        done_d    = 1'b0;

        if (START) begin
            // START wins in every state: reseed and begin a new frame.
            state_d = ST_SHIFT_IN;
            mode_d  = CHECK_MODE;
            err_d   = 1'b0;
            lfsr_d  = ACTIVE ? step_c : SEED;
        end else begin
            case (state_q)
                ST_SHIFT_IN: begin
                    if (ACTIVE) begin
                        lfsr_d = step_c;
                    end else begin
                        crc_val_d = lfsr_q;
                        if (mode_q) begin
                            state_d = ST_CHK_DONE;
                            done_d  = 1'b1;
                            err_d   = (lfsr_q != '0);
                        end else begin
                            state_d = ST_SHIFT_OUT;
                            cnt_d   = CNT_W'(CRC_W);
                        end
                    end
                end
                ST_SHIFT_OUT: begin
                    if (OUT_READY) begin
                        lfsr_d = lfsr_q >> 1;
                        cnt_d  = cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                ST_CHK_DONE: state_d = ST_IDLE;
                default:     state_d = ST_IDLE;
            endcase
        end

        valid_d = (state_d == ST_SHIFT_OUT);
        crc_d   = valid_d & lfsr_d[0];
        busy_d  = (state_d != ST_IDLE);
    end

    // All state and outputs registered.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            lfsr_q  <= SEED;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            Valid   <= 1'b0;
            CRC     <= 1'b0;
            CRC_VAL <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            CRC_ERR <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            Valid   <= valid_d;
            CRC     <= crc_d;
            CRC_VAL <= crc_val_d;
            BUSY    <= busy_d;
            DONE    <= done_d;
            CRC_ERR <= err_d;
        end
    end

endmodule

// File: tb/tb_crc_engine.sv
// Self-checking bench for crc_engine: scoreboard of serial CRC bits plus
// per-scenario inline checks.
module tb_crc_engine;

    localparam int unsigned CRC_W = 8;
    localparam logic [7:0]  POLY  = 8'hC4;
    localparam logic [7:0]  SEED  = 8'hD8;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       check_mode;
    logic       active;
    logic       data;
    logic       out_ready;
    logic       valid;
    logic       crc;
    logic [7:0] crc_val;
    logic       busy;
    logic       done;
    logic       crc_err;

    int checks = 0;
    int errors = 0;
    int beats  = 0;
    logic q[$];
    logic done_prev = 1'b0;

    crc_engine #(
        .CRC_W (CRC_W),
        .POLY  (POLY),
        .SEED  (SEED)
    ) dut (
        .CLK        (clk),
        .RST        (rst_n),
        .START      (start),
        .CHECK_MODE (check_mode),
        .ACTIVE     (active),
        .DATA       (data),
        .OUT_READY  (out_ready),
        .Valid      (valid),
        .CRC        (crc),
        .CRC_VAL    (crc_val),
        .BUSY       (busy),
        .DONE       (done),
        .CRC_ERR    (crc_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model_crc(input logic [31:0] bits, input int n);
        logic [7:0] l;
        logic       fb;
        l = SEED;
        for (int i = 0; i < n; i++) begin
            fb = l[0] ^ bits[i];
            l  = {fb, l[7:1]} ^ ({1'b0, POLY[6:0]} & {8{fb}});
        end
        return l;
    endfunction

    // Scoreboard: every accepted beat must match the next expected bit.
    always @(negedge clk) begin
        logic exp_bit;
        if (valid && out_ready) begin
            beats++;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL serial_beat: unexpected beat crc=%0b, none expected", crc);
            end else begin
                exp_bit = q.pop_front();
                if (crc !== exp_bit) begin
                    errors++;
                    $display("FAIL serial_beat: crc=%0b expected %0b", crc, exp_bit);
                end
            end
        end
        if (done) begin
            checks++;
            if (done_prev) begin
                errors++;
                $display("FAIL done_pulse: DONE high two cycles in a row");
            end
        end
        done_prev = done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one frame starting with START; leaves inputs idle after the end-of-frame edge.
    task automatic send_frame(input logic mode, input logic [31:0] bits, input int n);
        logic [7:0] exp_crc;
        start      = 1'b1;
        check_mode = mode;
        active     = 1'b1;
        data       = bits[0];
        tick();
        start = 1'b0;
        for (int i = 1; i < n; i++) begin
            data = bits[i];
            tick();
        end
        active = 1'b0;
        data   = 1'b0;
        if (!mode) begin
            exp_crc = model_crc(bits, n);
            for (int i = 0; i < 8; i++) q.push_back(exp_crc[i]);
        end
        tick();
    endtask

    task automatic wait_done(output int cycles, output bit ok);
        cycles = 0;
        while (!done && cycles < 40) begin
            tick();
            cycles++;
        end
        ok = done;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (valid !== 1'b0)   begin errors++; $display("FAIL reset_valid: got %0b expected 0", valid); end
        checks++; if (crc !== 1'b0)     begin errors++; $display("FAIL reset_crc: got %0b expected 0", crc); end
        checks++; if (crc_val !== 8'h0) begin errors++; $display("FAIL reset_crc_val: got %h expected 00", crc_val); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
        checks++; if (crc_err !== 1'b0) begin errors++; $display("FAIL reset_crc_err: got %0b expected 0", crc_err); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %0b expected 0", busy); end
    endtask

    task automatic test_generate(input logic bit_in, input logic [7:0] exp_val);
        int  cyc;
        bit  ok;
        int  b0;
        logic [31:0] bits;
        bits = '0;
        bits[0] = bit_in;
        b0 = beats;
        send_frame(1'b0, bits, 1);
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL gen_valid_rise: got %0b expected 1", valid); end
        checks++; if (crc_val !== exp_val) begin errors++; $display("FAIL gen_crc_val: got %h expected %h", crc_val, exp_val); end
        wait_done(cyc, ok);
        checks++; if (!ok || cyc != 8) begin errors++; $display("FAIL gen_done_timing: cycles=%0d done=%0b expected 8 and 1", cyc, done); end
        checks++; if (beats - b0 != 8) begin errors++; $display("FAIL gen_beats: got %0d expected 8", beats - b0); end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL gen_queue: %0d bits left expected 0", q.size()); end
        checks++; if (valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL gen_idle: valid=%0b busy=%0b expected 0 0", valid, busy); end
    endtask

    task automatic test_check(input logic flip, input logic exp_err);
        logic [31:0] bits;
        bits = '0;
        bits[0] = 1'b1;
        bits[4] = 1'b1;
        bits[6] = 1'b1;
        bits[8] = 1'b1;
        if (flip) bits[4] = 1'b0;
        send_frame(1'b1, bits, 9);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL chk_done: got %0b expected 1", done); end
        checks++; if (crc_err !== exp_err) begin errors++; $display("FAIL chk_err: got %0b expected %0b", crc_err, exp_err); end
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL chk_after: done=%0b busy=%0b expected 0 0", done, busy); end
        checks++; if (crc_err !== exp_err) begin errors++; $display("FAIL chk_err_hold: got %0b expected %0b", crc_err, exp_err); end
    endtask

    task automatic test_backpressure();
        int   cyc;
        bit   ok;
        int   b0;
        logic held;
        logic [31:0] bits;
        logic [7:0]  exp_crc;
        bits = 32'h1;
        exp_crc = model_crc(bits, 1);
        b0 = beats;
        send_frame(1'b0, bits, 1);
        tick();
        tick();
        tick();
        out_ready = 1'b0;
        held = crc;
        checks++; if (held !== exp_crc[3]) begin errors++; $display("FAIL bp_bit: got %0b expected %0b", held, exp_crc[3]); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (valid !== 1'b1 || crc !== held) begin
                errors++;
                $display("FAIL bp_hold: valid=%0b crc=%0b expected 1 %0b", valid, crc, held);
            end
        end
        out_ready = 1'b1;
        wait_done(cyc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_done: timed out waiting for DONE"); end
        checks++; if (beats - b0 != 8) begin errors++; $display("FAIL bp_beats: got %0d expected 8", beats - b0); end
    endtask

    task automatic test_abort();
        int  cyc;
        bit  ok;
        logic [31:0] bits;
        logic [7:0]  exp_crc;
        bits = '0;
        send_frame(1'b0, bits, 1);
        tick();
        tick();
        tick();
        start     = 1'b1;
        active    = 1'b1;
        data      = 1'b1;
        out_ready = 1'b0;
        tick();
        checks++; if (valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL abort_valid: valid=%0b busy=%0b expected 0 1", valid, busy); end
        q.delete();
        start     = 1'b0;
        active    = 1'b0;
        data      = 1'b0;
        out_ready = 1'b1;
        bits = 32'h1;
        exp_crc = model_crc(bits, 1);
        for (int i = 0; i < 8; i++) q.push_back(exp_crc[i]);
        tick();
        checks++; if (crc_val !== 8'hA8) begin errors++; $display("FAIL abort_crc_val: got %h expected a8", crc_val); end
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL abort_restart_valid: got %0b expected 1", valid); end
        wait_done(cyc, ok);
        checks++; if (!ok || cyc != 8) begin errors++; $display("FAIL abort_done: cycles=%0d done=%0b expected 8 and 1", cyc, done); end
    endtask

    task automatic test_back_to_back();
        int  cyc;
        bit  ok;
        logic [31:0] bits;
        bits = 32'h151;
        send_frame(1'b1, bits, 9);
        checks++; if (done !== 1'b1 || crc_err !== 1'b0) begin errors++; $display("FAIL b2b_chk: done=%0b err=%0b expected 1 0", done, crc_err); end
        send_frame(1'b0, 32'h0, 1);
        checks++; if (crc_val !== 8'h6C) begin errors++; $display("FAIL b2b_crc_val: got %h expected 6c", crc_val); end
        wait_done(cyc, ok);
        checks++; if (!ok || cyc != 8) begin errors++; $display("FAIL b2b_done: cycles=%0d done=%0b expected 8 and 1", cyc, done); end
    endtask

    task automatic test_random();
        int  cyc;
        bit  ok;
        int  n;
        logic [31:0] bits;
        logic [7:0]  exp_crc;
        for (int k = 0; k < 4; k++) begin
            n    = $urandom_range(12, 2);
            bits = $urandom();
            exp_crc = model_crc(bits, n);
            send_frame(1'b0, bits, n);
            checks++; if (crc_val !== exp_crc) begin errors++; $display("FAIL rand_crc_val: frame %0d got %h expected %h", k, crc_val, exp_crc); end
            wait_done(cyc, ok);
            checks++; if (!ok) begin errors++; $display("FAIL rand_done: frame %0d timed out", k); end
        end
    endtask

    task automatic test_reset_mid_frame();
        start  = 1'b1;
        active = 1'b1;
        data   = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (valid !== 1'b0 || crc !== 1'b0 || crc_val !== 8'h0 || busy !== 1'b0 || done !== 1'b0 || crc_err !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: valid=%0b crc=%0b crc_val=%h busy=%0b done=%0b err=%0b expected all 0",
                     valid, crc, crc_val, busy, done, crc_err);
        end
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || valid !== 1'b0) begin
                errors++;
                $display("FAIL ignore_active: busy=%0b valid=%0b expected 0 0", busy, valid);
            end
        end
        active = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || crc_val !== 8'h0) begin errors++; $display("FAIL ignore_active_end: busy=%0b crc_val=%h expected 0 00", busy, crc_val); end
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        check_mode = 1'b0;
        active     = 1'b0;
        data       = 1'b0;
        out_ready  = 1'b1;
        test_reset();
        test_generate(1'b0, 8'h6C);
        test_generate(1'b1, 8'hA8);
        test_check(1'b0, 1'b0);
        test_check(1'b1, 1'b1);
        test_backpressure();
        test_abort();
        test_back_to_back();
        test_random();
        test_reset_mid_frame();
        checks++; if (q.size() != 0) begin errors++; $display("FAIL final_queue: %0d bits left expected 0", q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/crc_engine.md
Name: crc_engine

Overview:
Parametrised serial CRC engine (LFSR) with selectable generate/check mode, explicit frame start and an output handshake on the serialized CRC. Successor to the team's fixed 8-bit serial CRC: the width, polynomial and seed are parameters. It adds backpressure on the CRC stream, a parallel CRC snapshot and a residue check. It sits between the serial frame source and the line encoder / receive framer.

Parameters:
CRC_W, 8, CRC width in bits; legal range 2..32.
POLY, 8'hC4, tap mask; bit i=1 means LFSR[i] receives the feedback XOR, i=0..CRC_W-2; bit CRC_W-1 is ignored because the MSB always takes the feedback.
SEED, 8'hD8, LFSR value loaded at every frame START.

Ports:
CLK  in  1  clock, rising edge.
RST  in  1  asynchronous active-low reset.
START  in  1  frame start pulse; reloads SEED and latches CHECK_MODE.
CHECK_MODE  in  1  0 = generate, 1 = check; sampled only when START=1.
ACTIVE  in  1  DATA bit valid this cycle.
DATA  in  1  serial frame bit.
OUT_READY  in  1  downstream accepts the current CRC bit.
Valid  out  1  CRC bit on CRC is valid.
CRC  out  1  serialized CRC, LSB (LFSR[0]) first.
CRC_VAL  out  CRC_W  parallel CRC snapshot taken at end of frame.
BUSY  out  1  engine is not IDLE.
DONE  out  1  one-cycle pulse at end of operation.
CRC_ERR  out  1  check-mode result; valid while DONE=1, held until the next START.

Behaviour:
- Reset (RST=0, asynchronous): state=IDLE, LFSR=SEED, counter=0, mode=0. Outputs: Valid=0, CRC=0, CRC_VAL=0, BUSY=0, DONE=0, CRC_ERR=0.
- LFSR step on an accepted bit:
  - fb = LFSR[0]^DATA
  - LFSR[CRC_W-1] <= fb
  - LFSR[i] <= LFSR[i+1] ^ (POLY[i] & fb)
- States:
  - IDLE, SHIFT_IN, SHIFT_OUT, CHK_DONE.
- IDLE:
  - START=1: LFSR<=SEED and mode<=CHECK_MODE; go to SHIFT_IN.
  - START=1 with ACTIVE=1 in the same cycle: the bit is stepped on SEED, not on the old LFSR.
  - ACTIVE without START: ignored.
- SHIFT_IN:
  - ACTIVE=1: step.
  - ACTIVE=0: end of frame. CRC_VAL<=LFSR.
    - Generate mode: counter<=CRC_W, go to SHIFT_OUT.
    - Check mode: go to CHK_DONE.
  - START=1: abort the frame, reseed, stay in SHIFT_IN; it is stepped if ACTIVE=1. START has priority over the end-of-frame decision.
- SHIFT_OUT:
  - Valid=1, CRC=LFSR[0].
  - OUT_READY=1: LFSR shifts right with zero fill, counter--.
  - OUT_READY=0: Valid, CRC and LFSR hold.
  - Beat accepted with counter=1: next cycle IDLE, DONE=1.
  - START=1: abort, reseed, go to SHIFT_IN; Valid drops the next cycle.
  - ACTIVE without START: ignored.
- CHK_DONE (one cycle): DONE=1, CRC_ERR=(LFSR!=0), then IDLE. START in this cycle is honoured exactly as in IDLE.
- Check-mode residue: the frame is data followed by the appended CRC, LSB first. A clean frame leaves LFSR=0.
- Latency:
  - Valid rises the cycle after the first ACTIVE=0 following the frame.
  - A full unstalled CRC takes CRC_W cycles.
- Output timing:
  - Outside SHIFT_OUT, Valid=0 and CRC=0.
  - All outputs are registered or decoded from registered state; there is no combinational path from input to output.
- Counter width is $clog2(CRC_W+1).
- BUSY = (state!=IDLE).
- DONE is never high for more than one cycle.

Decomposition:
- crc_pkg holds the state enum, the counter-width function and the legal-range check on CRC_W.
- One sub-module is natural: crc_lfsr_step, a combinational next-state function (LFSR, DATA, POLY -> next LFSR). It is reused by a future byte-parallel variant.

Test Plan:
- CRC_W=8, POLY=C4, SEED=D8; START+ACTIVE with DATA=0, then ACTIVE=0 -> CRC_VAL=0x6C; CRC bits 0,0,1,1,0,1,1,0 over 8 Valid cycles; DONE on the cycle after the last beat.
- Same configuration, DATA=1 -> CRC_VAL=0xA8; serial 0,0,0,1,0,1,0,1.
- Check mode: bit 1, then 0,0,0,1,0,1,0,1 -> CRC_ERR=0 with DONE. Flip the 4th appended bit -> CRC_ERR=1.
- Backpressure: hold OUT_READY=0 for 5 cycles mid-stream -> Valid and CRC frozen; total beats still 8 with unchanged values.
- START during SHIFT_OUT after 3 beats -> Valid=0 the next cycle; the new 1-bit frame gives CRC_VAL=0x6C or 0xA8 as above.
- RST asserted mid-SHIFT_IN -> all outputs 0 immediately; after release, ACTIVE without START is ignored and BUSY stays 0.
